// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART serialiser at a fixed clocks-per-bit rate.
// Producers push over wr_valid/wr_ready; the FSM drains one frame at a time, back to back.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DEPTH        = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [7:0]               wr_data,
  output logic                     wr_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q;
  logic [7:0]      mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            tx_q;
  logic            push_c;
  logic            pop_c;
  logic            bit_end_c;

  assign wr_ready   = (count_q != CW'(DEPTH));
  assign push_c     = wr_valid && wr_ready;
  assign bit_end_c  = (baud_q == BW'(CLKS_PER_BIT - 1));
  // The FSM consumes a byte when idle, or at the end of a stop bit to chain frames.
  assign pop_c      = (count_q != '0) &&
                      ((state_q == IDLE) || ((state_q == STOP) && bit_end_c));
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_c) wptr_d = wptr_q + PW'(1);
    if (pop_c)  rptr_d = rptr_q + PW'(1);
    if (push_c && !pop_c)      count_d = count_q + CW'(1);
    else if (pop_c && !push_c) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop_c) begin
            shift_q <= mem_q[rptr_q];
            tx_q    <= 1'b0;
            baud_q  <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end_c) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (bit_end_c) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        STOP: begin
          if (bit_end_c) begin
            baud_q <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (pop_c) begin
              shift_q <= mem_q[rptr_q];
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: a frame-level line model checks outputs every cycle,
// and a UART decoder pops a byte scoreboard for each received frame.
module tb_uart_tx_fifo;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 16;
  localparam int          FRAME = 10 * CPB;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   wr_valid;
  logic [7:0]             wr_data;
  logic                   wr_ready;
  logic                   tx;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Line model: queued bytes plus the frame currently on the wire (position in cycles).
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_cur    = 8'h00;
  bit         chk_en   = 1'b0;

  function automatic int exp_tx();
    int b;
    if (!m_active) return 1;
    b = m_pos / int'(CPB);
    if (b == 0) return 0;
    if (b == 9) return 1;
    return int'(m_cur[b-1]);
  endfunction

  // Compare the state after the last edge, then advance the model across the coming edge.
  always @(negedge clk) begin
    int  len0;
    bit  acc;
    bit  popnow;
    if (chk_en) begin
      check("tx",         int'(tx),         exp_tx());
      check("fifo_count", int'(fifo_count), mq.size());
      check("wr_ready",   int'(wr_ready),   (mq.size() != int'(DEPTH)) ? 1 : 0);
      check("busy",       int'(busy),       (m_active || mq.size() != 0) ? 1 : 0);
    end
    if (reset) begin
      mq.delete();
      sb.delete();
      m_active = 1'b0;
      m_pos    = 0;
      chk_en   = 1'b1;
    end else begin
      len0   = mq.size();
      acc    = wr_valid && (len0 < int'(DEPTH));
      popnow = 1'b0;
      if (m_active) begin
        m_pos++;
        if (m_pos == FRAME) begin
          m_active = 1'b0;
          popnow   = (len0 > 0);
        end
      end else begin
        popnow = (len0 > 0);
      end
      if (popnow) begin
        m_cur    = mq.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (acc) begin
        mq.push_back(wr_data);
        sb.push_back(wr_data);
      end
    end
  end

  // UART receiver: capture a whole frame from the falling start edge and score it.
  logic fr [FRAME];
  bit   mon_in = 1'b0;
  int   mon_k  = 0;

  always @(negedge clk) begin
    bit         shape_ok;
    logic [7:0] got;
    logic [7:0] want;
    if (reset) begin
      mon_in = 1'b0;
    end else if (!mon_in) begin
      if (chk_en && tx == 1'b0) begin
        mon_in = 1'b1;
        fr[0]  = 1'b0;
        mon_k  = 1;
      end
    end else begin
      fr[mon_k] = tx;
      mon_k++;
      if (mon_k == FRAME) begin
        mon_in   = 1'b0;
        shape_ok = (fr[0] == 1'b0) && (fr[9*CPB] == 1'b1);
        for (int b = 0; b < 10; b++)
          for (int j = 0; j < int'(CPB); j++)
            if (fr[b*CPB+j] !== fr[b*CPB]) shape_ok = 1'b0;
        for (int i = 0; i < 8; i++) got[i] = fr[(i+1)*CPB + CPB/2];
        check("frame_shape", int'(shape_ok), 1);
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL rx_unexpected: got frame 0x%02h expected no frame at t=%0t", got, $time);
        end else begin
          want = sb.pop_front();
          check("rx_byte", int'(got), int'(want));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer n bytes with wr_valid; junk is driven on wr_data whenever wr_ready is low.
  task automatic push_seq(input int n, input logic [7:0] base, input bit rnd, input int gap_pct);
    int         i     = 0;
    int         guard = 0;
    bit         acc;
    logic [7:0] cur;
    cur = rnd ? 8'($urandom) : base;
    while (i < n && guard < 20000) begin
      if (rnd && int'($urandom_range(99)) < gap_pct) begin
        wr_valid = 1'b0;
        wr_data  = 8'($urandom);
        tick();
      end else begin
        wr_valid = 1'b1;
        acc      = wr_ready;
        wr_data  = acc ? cur : 8'($urandom);
        tick();
        if (acc) begin
          i++;
          cur = rnd ? 8'($urandom) : base + 8'(i);
        end
      end
      guard++;
    end
    wr_valid = 1'b0;
    if (i < n) begin
      n_total++;
      $display("FAIL push_timeout: got %0d bytes accepted expected %0d", i, n);
    end
  endtask

  task automatic wait_idle(input int bound);
    int c = 0;
    while ((m_active || mq.size() != 0 || mon_in) && c < bound) begin
      tick();
      c++;
    end
    if (c >= bound) begin
      n_total++;
      $display("FAIL idle_timeout: got still busy after %0d cycles expected idle", c);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish by t=1000000");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    tick();

    push_seq(1, 8'h55, 1'b0, 0);
    wait_idle(200);
    repeat (3) tick();

    push_seq(1, 8'hA3, 1'b0, 0);
    push_seq(1, 8'h0F, 1'b0, 0);
    wait_idle(300);

    push_seq(20, 8'h00, 1'b0, 0);
    wait_idle(2000);

    push_seq(40, 8'h00, 1'b1, 10);
    wait_idle(3000);

    // Abort a frame in the middle of data bit 3 with five bytes still queued.
    push_seq(6, 8'hC0, 1'b0, 0);
    c = 0;
    while (!(m_active && m_pos == 4*int'(CPB) + 1) && c < 200) begin
      tick();
      c++;
    end
    check("reset_window_queued", mq.size(), 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("post_reset_tx",    int'(tx),         1);
    check("post_reset_count", int'(fifo_count), 0);
    check("post_reset_busy",  int'(busy),       0);
    repeat (100) tick();

    push_seq(200, 8'h00, 1'b1, 30);
    wait_idle(20000);
    push_seq(10, 8'h30, 1'b0, 0);
    wait_idle(1000);

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
